data_mem: RTL and testbench
===========================

# data_mem

Data-memory responder for the `risc_v` core. It is the far end of the core's `dm_rd_*` / `dm_wr_*` request interface and owns the word RAM plus two memory-mapped registers: a free-running cycle counter and a GPIO output latch. Read requests issued in the decode stage return data one cycle later, in time for execute. Write requests from execute commit on the same clock edge.

## Interface

**Parameters**
- `DEPTH`, default 1024: RAM size in 32-bit words; must be a power of two.
- `MMIO_BASE`, default 32'h1000_0000: base byte address of the register window.
- `GPIO_W`, default 8: width of the GPIO output latch.

**Ports**
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `dm_rd_req_i`, in, 1: read request, sampled each edge.
- `dm_rd_addr_i`, in, 32: read byte address.
- `dm_rd_data_o`, out, 32: registered read data.
- `dm_wr_req_i`, in, 1: write request.
- `dm_wr_addr_i`, in, 32: write byte address.
- `dm_wr_data_i`, in, 32: write data.
- `gpio_o`, out, GPIO_W: GPIO latch.
- `err_o`, out, 1: sticky access-error flag.

## Operation

**Address decode** (identical for read and write paths)
- RAM region: `addr < DEPTH*4`. Word index is `addr[2+log2(DEPTH)-1:2]`.
- CNT region: `addr == MMIO_BASE`.
- GPIO region: `addr == MMIO_BASE+4`.
- Everything else is NONE.
- Only word accesses are supported. `addr[1:0]` is ignored for indexing.

**Read behaviour**
- RAM: returns the stored word.
- CNT: returns the counter value.
- GPIO: returns the latch, zero-extended to 32 bits.
- NONE: returns 0.

**Write behaviour**
- RAM: stores the word.
- CNT: loads the counter with `dm_wr_data_i`.
- GPIO: loads the latch with `dm_wr_data_i[GPIO_W-1:0]`.
- NONE: the write is dropped.

**Errors**
- `err_o` sets on any accepted request (read or write) whose decode is NONE or whose `addr[1:0] != 0`.
- It stays set until `rst`.
- A misaligned access that decodes to a valid region is still performed, on the aligned word.

**Counter**
- 32-bit, increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
- A CNT write takes priority over the increment in that cycle. The counter holds `wdata` after the edge and increments from there.

**Collision**
- Read and write in the same cycle to the same decoded word or register: the read returns the write data (write-first).
- This applies to RAM, CNT and GPIO alike.

## Timing

**Reset values**
- `dm_rd_data_o` = 0, `gpio_o` = 0, `err_o` = 0, counter = 0.
- RAM contents are not reset.

**Read latency**
- `dm_rd_req_i` is sampled at edge N, and `dm_rd_data_o` is valid after edge N.
- The CNT value returned is the counter value before edge N. On a collision it is `wdata` instead.

**Hold**
- Without `dm_rd_req_i`, `dm_rd_data_o` keeps its last value.

**Writes**
- A write sampled at edge N is visible to a read sampled at edge N+1.
- Same-edge reads are covered by the collision rule above.

**Reset priority**
- `rst` overrides any same-cycle request: no write commits, and the read register clears.
- A read accepted at the edge before `rst` is overwritten to 0 by the reset edge.

**Protocol**
- No ready or valid handshake. Every request is accepted every cycle, and there is no backpressure.

## Structure

**Package `dm_pkg`**
- Region enum: `REG_RAM`, `REG_CNT`, `REG_GPIO`, `REG_NONE`.
- MMIO offset constants: `CNT_OFF=0`, `GPIO_OFF=4`.
- Decode function: `(addr, DEPTH, MMIO_BASE) -> region`.

**Sub-module `dm_ram`**
- Single write port plus single read port, with a registered read output and write-first bypass.
- Instantiated once by `data_mem`.

**Top level**
- Holds the decode, counter, GPIO latch, error flag and output mux.
- The region of the read is registered alongside the request so the output mux selects correctly one cycle later.

## Test plan

1. **RAM write then read.** Write 0xDEADBEEF to 0x10 at edge 1, then read 0x10 at edge 2 → `dm_rd_data_o` = 0xDEADBEEF after edge 2; `err_o` = 0.
2. **Collision.** Write 0x12345678 to 0x20 and read 0x20 in the same cycle → read data = 0x12345678, not the old word.
3. **Counter.** Release `rst`, then read `MMIO_BASE` on the 5th edge after release → returns 4. Write 0xFFFF_FFFE to the counter, then read 2 cycles later → returns 0xFFFF_FFFF, and the next read returns 0 (wrap).
4. **GPIO.** Write 0x1A5 to `MMIO_BASE+4` → `gpio_o` = 0xA5 after the edge. A read of the same address returns 0x0000_00A5.
5. **Errors.** Read 0x0800_0000 (DEPTH=1024) → data 0 and `err_o` = 1 thereafter. Write 0x13 → the RAM word at 0x10 is updated and `err_o` stays 1. `rst` → `err_o` = 0.
6. **Reset mid-operation.** Read accepted at edge N with `rst` asserted at edge N+1 → `dm_rd_data_o` = 0. A write requested during `rst` does not modify RAM, which is checked by a read after release.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and address decode for the data-memory responder.
// The RAM and the MMIO registers all share one decode function.
package dm_pkg;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_CNT  = 2'd1,
    REG_GPIO = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  localparam logic [31:0] CNT_OFF  = 32'd0;
  localparam logic [31:0] GPIO_OFF = 32'd4;

  // MMIO registers match on the word address, so a misaligned access lands on the aligned register.
  function automatic region_e decode(input logic [31:0] addr,
                                     input int unsigned depth,
                                     input logic [31:0] mmio_base);
    logic [33:0] ram_bytes;
    logic [31:0] word_addr;
    ram_bytes = 34'(depth) << 2;
    word_addr = {addr[31:2], 2'b00};
    if ({2'b00, addr} < ram_bytes)             return REG_RAM;
    else if (word_addr == mmio_base + CNT_OFF)  return REG_CNT;
    else if (word_addr == mmio_base + GPIO_OFF) return REG_GPIO;
    else                                        return REG_NONE;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response bus between the core and the data memory.
// No handshake: both requests are accepted every cycle, there is no ready and no backpressure.
interface data_mem_if;
  logic        dm_rd_req_i;
  logic [31:0] dm_rd_addr_i;
  logic [31:0] dm_rd_data_o;
  logic        dm_wr_req_i;
  logic [31:0] dm_wr_addr_i;
  logic [31:0] dm_wr_data_i;

  modport master (
    output dm_rd_req_i, dm_rd_addr_i, dm_wr_req_i, dm_wr_addr_i, dm_wr_data_i,
    input  dm_rd_data_o
  );

  modport slave (
    input  dm_rd_req_i, dm_rd_addr_i, dm_wr_req_i, dm_wr_addr_i, dm_wr_data_i,
    output dm_rd_data_o
  );
endinterface

// File: rtl/dm_ram.sv
// Word RAM: one write port, one registered read port, write-first on a same-word collision.
// Contents are not reset; only the read register clears.
module dm_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/data_mem.sv
// Data-memory responder: word RAM plus a free-running cycle counter and a GPIO latch.
// Reads return one edge after the request; writes commit on the request edge.
module data_mem
  import dm_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_if.slave         bus,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              err_o
);

  localparam int AW = $clog2(DEPTH);

  region_e     rd_region, wr_region, rd_region_q;
  logic [31:0] cnt_q;
  logic [31:0] mmio_rdata, mmio_q;
  logic [31:0] ram_rdata;
  logic        ram_we, ram_re, rd_bad, wr_bad;

  always_comb begin
    rd_region = decode(bus.dm_rd_addr_i, DEPTH, MMIO_BASE);
    wr_region = decode(bus.dm_wr_addr_i, DEPTH, MMIO_BASE);
    ram_we    = bus.dm_wr_req_i && (wr_region == REG_RAM);
    ram_re    = bus.dm_rd_req_i && (rd_region == REG_RAM);
    rd_bad    = bus.dm_rd_req_i &&
                ((rd_region == REG_NONE) || (bus.dm_rd_addr_i[1:0] != 2'b00));
    wr_bad    = bus.dm_wr_req_i &&
                ((wr_region == REG_NONE) || (bus.dm_wr_addr_i[1:0] != 2'b00));
  end

  dm_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (bus.dm_wr_addr_i[AW+1:2]),
    .wdata (bus.dm_wr_data_i),
    .re    (ram_re),
    .raddr (bus.dm_rd_addr_i[AW+1:2]),
    .rdata (ram_rdata)
  );

  // Register reads see a same-edge write to the same register (write-first), matching the RAM.
  always_comb begin
    mmio_rdata = 32'd0;
    case (rd_region)
      REG_CNT:
        mmio_rdata = (bus.dm_wr_req_i && wr_region == REG_CNT) ? bus.dm_wr_data_i : cnt_q;
      REG_GPIO:
        mmio_rdata = (bus.dm_wr_req_i && wr_region == REG_GPIO) ?
                     32'(bus.dm_wr_data_i[GPIO_W-1:0]) : 32'(gpio_o);
      default:
        mmio_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_region_q <= REG_NONE;
      mmio_q      <= 32'd0;
    end else if (bus.dm_rd_req_i) begin
      rd_region_q <= rd_region;
      mmio_q      <= mmio_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else if (bus.dm_wr_req_i && wr_region == REG_CNT) begin
      cnt_q <= bus.dm_wr_data_i;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_o <= '0;
    end else if (bus.dm_wr_req_i && wr_region == REG_GPIO) begin
      gpio_o <= bus.dm_wr_data_i[GPIO_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                   err_o <= 1'b0;
    else if (rd_bad || wr_bad) err_o <= 1'b1;
  end

  // Region registered with the read selects RAM or register data one cycle later.
  always_comb begin
    bus.dm_rd_data_o = (rd_region_q == REG_RAM) ? ram_rdata : mmio_q;
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: counter sequences by hand, then a table of
// single-cycle vectors covering RAM, collision, GPIO, errors and reset.
module tb_data_mem;
  import dm_pkg::*;

  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;
  localparam logic [31:0] CNT_A     = MMIO_BASE;
  localparam logic [31:0] GPIO_A    = MMIO_BASE + 32'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gpio;
  logic       err;
  int         n_pass  = 0;
  int         n_total = 0;

  data_mem_if bus ();

  data_mem #(.DEPTH(1024), .MMIO_BASE(MMIO_BASE), .GPIO_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .gpio_o (gpio),
    .err_o  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_gpio;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic r, input logic wr, input logic [31:0] waddr,
                      input logic [31:0] wdata, input logic rd, input logic [31:0] raddr);
    rst              = r;
    bus.dm_wr_req_i  = wr;
    bus.dm_wr_addr_i = waddr;
    bus.dm_wr_data_i = wdata;
    bus.dm_rd_req_i  = rd;
    bus.dm_rd_addr_i = raddr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0,  32'h0000_0055, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h10, 32'hDEAD_BEEF, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h20, 32'h1111_1111, 1'b0, 32'h0,  32'hDEAD_BEEF, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b1, 32'h20, 32'h1234_5678, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h20, 32'h1234_5678, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h10, 32'hDEAD_BEEF, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, GPIO_A, 32'h0000_01A5, 1'b0, 32'h0,  32'hDEAD_BEEF, 8'hA5, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, GPIO_A, 32'h0000_00A5, 8'hA5, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, GPIO_A, 32'hFFFF_FF3C, 1'b1, GPIO_A, 32'h0000_003C, 8'h3C, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 1'b1, 32'h10, 32'hDEAD_BEEF, 8'h3C, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h30, 32'hCAFE_F00D, 8'h3C, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h0800_0000, 32'h0,  8'h3C, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h13, 32'hA5A5_5A5A, 1'b0, 32'h0,  32'h0,         8'h3C, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h10, 32'hA5A5_5A5A, 8'h3C, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, 1'b1, 32'h10, 32'h0,         8'h00, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h10, 32'hA5A5_5A5A, 8'h00, 1'b0};

    // Reset state
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    check("reset_rd_data", bus.dm_rd_data_o, 32'd0);
    check("reset_gpio", 32'(gpio), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    // Counter: read on the 5th edge after release returns 4
    for (int i = 0; i < 4; i++) idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, CNT_A);
    check("cnt_after_release", bus.dm_rd_data_o, 32'd4);
    step(1'b0, 1'b1, CNT_A, 32'hFFFF_FFFE, 1'b0, 32'd0);
    check("cnt_rd_hold", bus.dm_rd_data_o, 32'd4);
    idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, CNT_A);
    check("cnt_load_incr", bus.dm_rd_data_o, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, CNT_A);
    check("cnt_wrap", bus.dm_rd_data_o, 32'd0);
    step(1'b0, 1'b1, CNT_A, 32'h0000_0055, 1'b1, CNT_A);
    check("cnt_collision", bus.dm_rd_data_o, 32'h0000_0055);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, CNT_A);
    check("cnt_after_load", bus.dm_rd_data_o, 32'h0000_0055);

    // Table of single-cycle vectors
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].rd, vecs[i].raddr);
      check($sformatf("vec%0d_rd_data", i), bus.dm_rd_data_o, vecs[i].exp_rd);
      check($sformatf("vec%0d_gpio", i), 32'(gpio), 32'(vecs[i].exp_gpio));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
    end

    // Read at edge N, reset at edge N+1 clears the returned data
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h30);
    check("pre_reset_read", bus.dm_rd_data_o, 32'hCAFE_F00D);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    check("reset_clears_read", bus.dm_rd_data_o, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, CNT_A);
    check("cnt_first_edge", bus.dm_rd_data_o, 32'd0);
    idle();
    check("read_hold_idle", bus.dm_rd_data_o, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h30);
    check("ram_survives_reset", bus.dm_rd_data_o, 32'hCAFE_F00D);
    check("err_clear_after_reset", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
